// File: rtl/scrambler_pkg.sv
// Shared definitions for the 802.11-style s^7+s^4+1 scrambler and descrambler:
// field widths, polynomial taps, descrambler FSM encoding and seed recovery.
package scrambler_pkg;

   localparam int SEED_W    = 7;
   localparam int TAIL_W    = 7;
   localparam int SERVICE_W = 7;
   localparam int TAP_A     = 7;
   localparam int TAP_B     = 4;

   typedef enum logic {
      SYNC = 1'b0,
      RUN  = 1'b1
   } descState_t;

   // Runs x[n-7] = x[n] ^ x[n-4] backwards from x[0..6]; bit 0 of the result is the oldest state bit.
   function automatic logic [SEED_W-1:0] recoverSeed(input logic [SERVICE_W-1:0] head);
      logic [SEED_W+SERVICE_W-1:0] ext;
      ext = '0;
      ext[SEED_W +: SERVICE_W] = head;
      for (int i = SEED_W - 1; i >= 0; i--) begin
         ext[i] = ext[i + TAP_A] ^ ext[i + TAP_A - TAP_B];
      end
      return ext[SEED_W-1:0];
   endfunction

endpackage

// File: rtl/lfsr_expand.sv
// Expands a 7-bit scrambler state (bit 0 oldest) into the next WIDTH sequence bits.
// Purely combinational so the scrambler and descrambler can share it.
module lfsr_expand
   import scrambler_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [SEED_W-1:0] state_i,
   output logic [WIDTH-1:0]  seq_o
);

   logic [WIDTH+SEED_W-1:0] ext;

   always_comb begin
      ext = '0;
      ext[SEED_W-1:0] = state_i;
      for (int i = SEED_W; i < WIDTH + SEED_W; i++) begin
         ext[i] = ext[i - TAP_A] ^ ext[i - TAP_B];
      end
   end

   assign seq_o = ext[WIDTH+SEED_W-1:SEED_W];

endmodule

// File: rtl/descrambler.sv
// Self-synchronising frame descrambler: recovers the scrambler state from the
// zero SERVICE field of each frame's first word, then descrambles with the LFSR.
module descrambler
   import scrambler_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [WIDTH-1:0]  s_axis_tdata,
   input  logic [3:0]        s_axis_tuser,
   input  logic              s_axis_tvalid,
   input  logic              s_axis_tlast,
   output logic              s_axis_tready,
   output logic [WIDTH-1:0]  m_axis_tdata,
   output logic [3:0]        m_axis_tuser,
   output logic              m_axis_tvalid,
   output logic              m_axis_tlast,
   input  logic              m_axis_tready,
   output logic [SEED_W-1:0] seed,
   output logic              seed_err
);

   descState_t        state_q, state_d;
   logic [SEED_W-1:0] lfsr_q, lfsr_d;
   logic [WIDTH-1:0]  mData_q, mData_d;
   logic [3:0]        mUser_q, mUser_d;
   logic              mLast_q, mLast_d;
   logic              mValid_q, mValid_d;
   logic [SEED_W-1:0] seed_q, seed_d;
   logic              seedErr_q, seedErr_d;

   logic              sHandshake;
   logic [SEED_W-1:0] expState;
   logic [WIDTH-1:0]  expSeq;
   logic [WIDTH-1:0]  seqWord;
   logic [WIDTH-1:0]  descrWord;

   assign s_axis_tready = m_axis_tready;
   assign sHandshake    = s_axis_tvalid & m_axis_tready;

   // A frame's first word carries its own state: the scrambled SERVICE bits are x[0..6].
   assign expState = (state_q == SYNC) ? s_axis_tdata[SERVICE_W-1:0] : lfsr_q;

   lfsr_expand #(
      .WIDTH(WIDTH)
   ) u_expand (
      .state_i(expState),
      .seq_o  (expSeq)
   );

   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      mData_d   = mData_q;
      mUser_d   = mUser_q;
      mLast_d   = mLast_q;
      mValid_d  = mValid_q;
      seed_d    = seed_q;
      seedErr_d = seedErr_q;

      if (state_q == SYNC) begin
         seqWord = {expSeq[WIDTH-SERVICE_W-1:0], s_axis_tdata[SERVICE_W-1:0]};
      end else begin
         seqWord = expSeq;
      end

      descrWord = s_axis_tdata ^ seqWord;
      if (state_q == SYNC) begin
         descrWord[SERVICE_W-1:0] = '0;
      end
      if (s_axis_tlast) begin
         descrWord[WIDTH-1 -: TAIL_W] = '0;
      end

      // Output stage only moves on a slave handshake; otherwise a taken word just drops valid.
      if (sHandshake) begin
         mData_d  = descrWord;
         mUser_d  = s_axis_tuser;
         mLast_d  = s_axis_tlast;
         mValid_d = 1'b1;
         lfsr_d   = seqWord[WIDTH-1 -: SEED_W];
         if (state_q == SYNC) begin
            seed_d    = recoverSeed(s_axis_tdata[SERVICE_W-1:0]);
            seedErr_d = (s_axis_tdata[SERVICE_W-1:0] == '0);
         end
         state_d = s_axis_tlast ? SYNC : RUN;
      end else if (m_axis_tready) begin
         mValid_d = 1'b0;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q   <= SYNC;
         lfsr_q    <= '0;
         mData_q   <= '0;
         mUser_q   <= '0;
         mLast_q   <= 1'b0;
         mValid_q  <= 1'b0;
         seed_q    <= '0;
         seedErr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         mData_q   <= mData_d;
         mUser_q   <= mUser_d;
         mLast_q   <= mLast_d;
         mValid_q  <= mValid_d;
         seed_q    <= seed_d;
         seedErr_q <= seedErr_d;
      end
   end

   assign m_axis_tdata  = mData_q;
   assign m_axis_tuser  = mUser_q;
   assign m_axis_tlast  = mLast_q;
   assign m_axis_tvalid = mValid_q;
   assign seed          = seed_q;
   assign seed_err      = seedErr_q;

endmodule
